// File: rtl/btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond -- push-button conditioner for one front-panel button.
//
// Takes the raw, asynchronous button pad and turns it into clean control
// events for the stopwatch control FSM, all in the clk_dcm domain:
//   - a two-flop synchronizer,
//   - a debounce FSM that accepts a level change only after DEBOUNCE_CYCLES
//     consecutive stable synchronized samples,
//   - registered one-cycle press / release / long-press pulses and a stable
//     pressed level.
//
// Ports:
//   CLK            in   system clock (clk_dcm domain)
//   RESET          in   synchronous, active-high reset
//   BTN_RAW        in   raw asynchronous button pad
//   BTN_LEVEL      out  debounced level, 1 = pressed
//   PRESS_PULSE    out  one-cycle pulse on an accepted press
//   RELEASE_PULSE  out  one-cycle pulse on an accepted release
//   LONG_PULSE     out  one-cycle pulse once a press has been held
//                       LONG_PRESS_CYCLES cycles (once per press)
//
// Build option:
//   BTN_COND_AUTOREPEAT_EN  when defined, PRESS_PULSE re-fires every
//                           REPEAT_CYCLES cycles after LONG_PULSE while the
//                           button stays held. When undefined no repeat logic
//                           exists and PRESS_PULSE fires once per press.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module btn_cond #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1024,
  parameter int REPEAT_CYCLES     = 256,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int CNT_W             = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic BTN_LEVEL,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE
);

  localparam logic [1:0] ST_RELEASED   = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
`ifdef BTN_COND_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Reject parameter sets the counters or the FSM cannot honour.
  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_CYCLES < 1 || CNT_W < 2 || CNT_W > 30 ||
      ((1 << CNT_W) - 1) < LONG_PRESS_CYCLES ||
      ((1 << CNT_W) - 1) < REPEAT_CYCLES) begin : g_param_check
    $error("btn_cond: illegal parameter combination");
  end

  logic             s1;
  logic             s2;
  logic             btn_s;     // synchronized, polarity-normalized: 1 = pressed
  logic [1:0]       state;
  logic [CNT_W-1:0] db_cnt;    // debounce run length
  logic [CNT_W-1:0] hold_cnt;  // long-press timer, frozen while a release is debounced
`ifdef BTN_COND_AUTOREPEAT_EN
  logic [CNT_W-1:0] rep_cnt;   // auto-repeat period timer
`endif

  assign btn_s = s2 ^ ACTIVE_LOW;

  // NOTE: all state here is updated with non-blocking assignments so that every
  // register samples pre-edge values; s2 <= s1 must see the old s1 for the
  // synchronizer to be two stages deep.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Synchronizer loads the released pad value so no phantom press appears.
      s1            <= ACTIVE_LOW;
      s2            <= ACTIVE_LOW;
      state         <= ST_RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      BTN_LEVEL     <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PULSE    <= 1'b0;
`ifdef BTN_COND_AUTOREPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      s1 <= BTN_RAW;
      s2 <= s1;

      // Pulses are low unless a transition below raises them for one cycle.
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PULSE    <= 1'b0;

      case (state)
        ST_RELEASED: begin
          if (btn_s) begin
            state  <= ST_PRESS_DB;
            db_cnt <= CNT_ONE;
          end
        end

        ST_PRESS_DB: begin
          if (!btn_s) begin
            state  <= ST_RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state       <= ST_HELD;
            BTN_LEVEL   <= 1'b1;
            PRESS_PULSE <= 1'b1;
            db_cnt      <= '0;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end

        ST_HELD: begin
          if (!btn_s) begin
            state  <= ST_RELEASE_DB;
            db_cnt <= CNT_ONE;
`ifdef BTN_COND_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            // Saturating at HOLD_MAX guarantees a single LONG_PULSE per press.
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + CNT_ONE;
            end
            LONG_PULSE <= (hold_cnt == HOLD_LAST);
`ifdef BTN_COND_AUTOREPEAT_EN
            // Repeats start only once the long press has fired.
            if (hold_cnt == HOLD_MAX) begin
              if (rep_cnt == REP_LAST) begin
                PRESS_PULSE <= 1'b1;
                rep_cnt     <= '0;
              end else begin
                rep_cnt <= rep_cnt + CNT_ONE;
              end
            end
`endif
          end
        end

        ST_RELEASE_DB: begin
          if (btn_s) begin
            // Release bounce: hold_cnt was left untouched, so long-press
            // timing simply resumes.
            state  <= ST_HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state         <= ST_RELEASED;
            BTN_LEVEL     <= 1'b0;
            RELEASE_PULSE <= 1'b1;
            db_cnt        <= '0;
            hold_cnt      <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end

        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// -----------------------------------------------------------------------------
// tb_btn_cond -- self-checking bench for btn_cond (N=4, L=20, R=8, active-low).
//
// A table of per-cycle vectors covers reset, first-press latency, release
// latency and short glitches; hand-written sequences cover long press, release
// bounce during hold and reset in the middle of debounce/hold; a randomized
// run is compared cycle by cycle against a run-length reference model.
// Build with +define+BTN_COND_AUTOREPEAT_EN to exercise auto-repeat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_btn_cond;

  localparam int N = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b1;
  logic level, press, rel, lng;
  logic [3:0] outs;

  int total = 0;
  int bad   = 0;

  btn_cond #(
    .DEBOUNCE_CYCLES  (N),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R),
    .ACTIVE_LOW       (1'b1),
    .CNT_W            (16)
  ) dut (
    .CLK          (clk),
    .RESET        (reset),
    .BTN_RAW      (btn_raw),
    .BTN_LEVEL    (level),
    .PRESS_PULSE  (press),
    .RELEASE_PULSE(rel),
    .LONG_PULSE   (lng)
  );

  always #5 clk = ~clk;

  // Bit order used for every packed output comparison.
  assign outs = {level, press, rel, lng};

  // ---------------------------------------------------------------------------
  // Reference model: the debounced level flips when the synchronized sample
  // stream has run N samples at the opposite value. The long-press timer counts
  // pressed samples whose predecessor was also pressed while the level is high.
  // ---------------------------------------------------------------------------
  bit h1, h2, prev_s, run_val;
  int run_len, held_q, rep_q;
  bit m_level, m_press, m_rel, m_long;

  function automatic void model_step(input bit rst, input bit pressed);
    bit s;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (rst) begin
      h1 = 0; h2 = 0; prev_s = 0; run_val = 0; run_len = 0;
      m_level = 0; held_q = 0; rep_q = 0;
      return;
    end
    s  = h2;
    h2 = h1;
    h1 = pressed;
    if (s == run_val) run_len++;
    else begin
      run_val = s;
      run_len = 1;
    end
    if (m_level && s && prev_s) begin
      held_q++;
      if (held_q == L) m_long = 1'b1;
`ifdef BTN_COND_AUTOREPEAT_EN
      if (held_q > L) begin
        rep_q++;
        if (rep_q == R) begin
          m_press = 1'b1;
          rep_q   = 0;
        end
      end
`endif
    end
    if (!s) rep_q = 0;
    if (run_len == N && run_val != m_level) begin
      m_level = run_val;
      if (run_val) begin
        m_press = 1'b1;
        held_q  = 0;
      end else begin
        m_rel = 1'b1;
      end
    end
    prev_s = s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs observed at the
  // next falling edge, model advanced at the rising edge in between.
  task automatic tick(input logic rst, input logic pressed);
    reset   = rst;
    btn_raw = ~pressed;
    @(posedge clk);
    model_step(rst, pressed);
    @(negedge clk);
  endtask

  // Holds the button level until outs[sel] is seen; n is the 1-based tick at
  // which it appeared, or 0 if the budget expired.
  task automatic ticks_until(input logic pressed, input int sel, input int budget,
                             output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick(1'b0, pressed);
      if (outs[sel]) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       pressed;
    logic [3:0] exp;   // {level, press, release, long}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic pressed, input logic [3:0] exp);
    vec_t v;
    v.rst = rst;
    v.pressed = pressed;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, t_press, t_long, t_rel, n_press, n_long, n_rel, last_press, lvl_drop, len;
    logic rp, rr;

    // ---------------- table-driven vectors ----------------
    add(1, 0, 4'b0000); add(1, 0, 4'b0000);
    for (int i = 0; i < 5; i++) add(0, 1, 4'b0000);   // edges k .. k+4
    add(0, 1, 4'b1100);                                // edge k+5: level + press
    add(0, 1, 4'b1000); add(0, 1, 4'b1000);
    for (int i = 0; i < 5; i++) add(0, 0, 4'b1000);   // release edges j .. j+4
    add(0, 0, 4'b0010);                                // edge j+5: release pulse
    add(0, 0, 4'b0000); add(0, 0, 4'b0000);
    for (int g = 1; g <= 3; g++) begin                 // 1, 2, 3 cycle glitches
      for (int i = 0; i < g; i++) add(0, 1, 4'b0000);
      for (int i = 0; i < g; i++) add(0, 0, 4'b0000);
      add(0, 0, 4'b0000);
    end

    @(negedge clk);
    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].pressed);
      check($sformatf("vec[%0d]", i), outs, vecs[i].exp);
    end

    // ---------------- long press, held 50 cycles ----------------
    tick(1, 0); tick(1, 0);
    n_press = 0; n_long = 0; t_press = 0; t_long = 0; last_press = 0; t_rel = 0; n_rel = 0;
    for (int t = 1; t <= 60; t++) begin
      tick(0, t <= 50);
      if (press) begin
        n_press++;
        if (t_press == 0) t_press = t;
        last_press = t;
      end
      if (lng) begin
        n_long++;
        t_long = t;
      end
      if (rel) begin
        n_rel++;
        if (t_rel == 0) t_rel = t - 50;
      end
    end
    check("long first press tick", t_press, 6);
    check("long delay after press", t_long - t_press, L);
    check("long pulse count", n_long, 1);
    check("long release latency", t_rel, 6);
    check("long release count", n_rel, 1);
`ifdef BTN_COND_AUTOREPEAT_EN
    check("repeat press count", n_press, 4);
    check("repeat last press tick", last_press, 50);
`else
    check("single press count", n_press, 1);
    check("single press last tick", last_press, 6);
`endif

    // ---------------- release bounce at hold_cnt = 10 ----------------
    tick(1, 0); tick(1, 0);
    lvl_drop = 0; t_long = 0; n_rel = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(0, !(t == 15 || t == 16));
      if (t >= 6 && !level) lvl_drop++;
      if (rel) n_rel++;
      if (lng) t_long = t;
    end
    check("bounce level drop", lvl_drop, 0);
    check("bounce release pulses", n_rel, 0);
    check("bounce long tick", t_long, 29);
    for (int t = 0; t < 8; t++) tick(0, 0);
    check("bounce final released", outs, 4'b0000);

    // ---------------- reset mid-PRESS_DB and mid-HELD ----------------
    tick(1, 0); tick(1, 0);
    for (int t = 0; t < 3; t++) tick(0, 1);
    tick(1, 1);
    check("reset mid press_db", outs, 4'b0000);
    ticks_until(1'b1, 2, 20, n);
    check("press after reset (db)", n, N + 2);
    for (int t = 0; t < 3; t++) tick(0, 1);
    check("held before reset", level, 1'b1);
    tick(1, 1);
    check("reset mid held", outs, 4'b0000);
    ticks_until(1'b1, 2, 20, n);
    check("press after reset (held)", n, N + 2);
    for (int t = 0; t < 8; t++) tick(0, 0);

    // ---------------- randomized run vs reference model ----------------
    for (int seg = 0; seg < 150; seg++) begin
      rp  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                        : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        rr = ($urandom_range(0, 199) == 0);
        tick(rr, rp);
        check("random outs", outs, {m_level, m_press, m_rel, m_long});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_cond.md
Name: btn_cond

Overview:
- Conditions one raw push-button input (e.g. STRTSTOP) into clean control events for the stopwatch state machine. It is the producer side of the button interface that statmach consumes.
- Synchronizes the asynchronous pad signal, debounces it, and emits single-cycle press, release and long-press pulses plus a stable level.
- Instantiated once per front-panel button, between the pad and the control FSM, in the clk_dcm domain.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples (N) required to accept a level change; must be ≥2.
- LONG_PRESS_CYCLES, 1024, number of cycles in HELD (L) before LONG_PULSE fires; must be > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 256, auto-repeat period (R); used only with the optional feature.
- ACTIVE_LOW, 1, 1 = raw pad is low when pressed; 0 = high when pressed.
- CNT_W, 16, width of the shared cycle counter; must hold max(N, L, R).

Ports:
- CLK  in  1  system clock (clk_dcm domain).
- RESET  in  1  synchronous, active-high reset.
- BTN_RAW  in  1  raw asynchronous button pad.
- BTN_LEVEL  out  1  debounced level, 1 = pressed.
- PRESS_PULSE  out  1  one-cycle pulse on an accepted press.
- RELEASE_PULSE  out  1  one-cycle pulse on an accepted release.
- LONG_PULSE  out  1  one-cycle pulse when a press has been held for L cycles; fires once per press.

Behaviour:
- Sync: two flops s1 → s2. btn_s = s2 XOR ACTIVE_LOW, so btn_s = 1 means pressed.
- FSM states:
  - RELEASED: BTN_LEVEL = 0. If btn_s = 1, go to PRESS_DB with cnt = 1.
  - PRESS_DB: if btn_s = 0, go to RELEASED with cnt = 0. Else if cnt == N-1, go to HELD, BTN_LEVEL ← 1, PRESS_PULSE = 1 for that cycle, cnt ← 0. Else cnt + 1.
  - HELD: BTN_LEVEL = 1. If btn_s = 0, go to RELEASE_DB with cnt = 1. Else cnt counts up, saturating at L. When cnt reaches L-1, LONG_PULSE = 1 for one cycle.
  - RELEASE_DB: if btn_s = 1, return to HELD; the long-press counter resumes and is not restarted. Else if cnt == N-1, go to RELEASED, BTN_LEVEL ← 0, RELEASE_PULSE = 1, cnt ← 0. Else cnt + 1.
- The long-press count and the debounce count are separate registers (hold_cnt and db_cnt), so a release glitch does not restart the long-press timing.
- Latency: a raw change sampled at rising edge k gives BTN_LEVEL and its pulse visible after edge k+1+N, i.e. N+2 edges.
- Glitch rule: any excursion shorter than N synchronized cycles produces no level change and no pulse.
- Pulses:
  - All pulse outputs are registered and exactly 1 cycle wide.
  - PRESS_PULSE and RELEASE_PULSE are never high in the same cycle.
  - LONG_PULSE never coincides with PRESS_PULSE, because L > N.
- Counter saturation: hold_cnt stops at L, so there is no wrap and no second LONG_PULSE however long the button is held.
- Reset:
  - RESET = 1 at an edge: s1 and s2 load the released value (= ACTIVE_LOW), state = RELEASED, all counters 0, all outputs 0.
  - Reset overrides everything, including mid-debounce and mid-hold.
  - If the button is still held after RESET deasserts, it is debounced normally and produces a PRESS_PULSE N+2 edges later.
- No combinational path from BTN_RAW to any output.

Optional Feature:
- Macro: BTN_COND_AUTOREPEAT_EN.
- Defined: after LONG_PULSE, while the FSM stays in HELD, PRESS_PULSE re-fires every R cycles (first repeat R cycles after LONG_PULSE). The repeat counter clears on leaving HELD or on RESET. BTN_LEVEL is unaffected.
- Undefined: no repeat logic is synthesized. PRESS_PULSE fires exactly once per accepted press.

Test Plan (N=4, L=20, R=8, ACTIVE_LOW=1):
- Reset, then drive BTN_RAW 1→0 before edge k and hold → BTN_LEVEL = 1 and PRESS_PULSE = 1 after edge k+5 only, and PRESS_PULSE = 0 the next cycle.
- Low glitches of 1, 2 and 3 cycles on BTN_RAW → BTN_LEVEL stays 0 and no pulse at all.
- Hold pressed 40 cycles, then release → exactly one LONG_PULSE, 20 cycles after PRESS_PULSE; RELEASE_PULSE 6 edges after the release; no second LONG_PULSE.
- While HELD, a 2-cycle release bounce at hold_cnt = 10 → BTN_LEVEL stays 1; LONG_PULSE still arrives with hold_cnt continuing uninterrupted from 10.
- Assert RESET mid-PRESS_DB and mid-HELD → all outputs 0 on the next edge; with the button still held after deassert → PRESS_PULSE after N+2 edges.
- With BTN_COND_AUTOREPEAT_EN, hold 50 cycles → LONG_PULSE, then PRESS_PULSE every 8 cycles until release; rebuilt without the macro → a single PRESS_PULSE.
